// File: rtl/i2c_target.sv
// I2C target endpoint: oversampled SCL/SDA, START/STOP detection, 7-bit address match,
// byte receive on writes and byte transmit on reads. SDA is open-drain (sda_oe pulls low).
module i2c_target #(
  parameter logic [6:0] ADDR = 7'b1000111
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  input  logic       sda_in,
  output logic       sda_oe,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_ACK_A = 3'd2,
    S_WR    = 3'd3,
    S_ACK_W = 3'd4,
    S_RD    = 3'd5,
    S_ACK_R = 3'd6
  } state_t;

  state_t      r_state, w_next_state;
  logic        r_scl_s1, r_scl_s2, r_scl_d;
  logic        r_sda_s1, r_sda_s2, r_sda_d;
  logic [7:0]  r_shift, w_shift;
  logic [3:0]  r_cnt, w_cnt;
  // ACK_A/ACK_W: ACK slot is being driven; ACK_R: master acknowledged the byte
  logic        r_phase, w_phase;
  logic        r_sda_oe, w_sda_oe;
  logic        r_tx_req, w_tx_req;
  logic        r_rx_valid, w_rx_valid;
  logic        r_busy, w_busy;
  logic [7:0]  r_rx_data, w_rx_data;
  logic        w_scl_rise, w_scl_fall, w_start, w_stop, w_addr_hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      {r_scl_s1, r_scl_s2, r_scl_d} <= '1;
      {r_sda_s1, r_sda_s2, r_sda_d} <= '1;
    end else begin
      r_scl_s1 <= scl;
      r_scl_s2 <= r_scl_s1;
      r_scl_d  <= r_scl_s2;
      r_sda_s1 <= sda_in;
      r_sda_s2 <= r_sda_s1;
      r_sda_d  <= r_sda_s2;
    end
  end

  // SCL edges take priority: an SDA edge in the same cycle is not a bus condition
  assign w_scl_rise = r_scl_s2 & ~r_scl_d;
  assign w_scl_fall = ~r_scl_s2 & r_scl_d;
  assign w_start    = ~w_scl_rise & ~w_scl_fall & r_scl_s2 & ~r_sda_s2 & r_sda_d;
  assign w_stop     = ~w_scl_rise & ~w_scl_fall & r_scl_s2 & r_sda_s2 & ~r_sda_d;
  assign w_addr_hit = (r_shift[6:0] == ADDR);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_cnt      <= '0;
      r_phase    <= 1'b0;
      r_sda_oe   <= 1'b0;
      r_tx_req   <= 1'b0;
      r_rx_valid <= 1'b0;
      r_rx_data  <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_shift    <= w_shift;
      r_cnt      <= w_cnt;
      r_phase    <= w_phase;
      r_sda_oe   <= w_sda_oe;
      r_tx_req   <= w_tx_req;
      r_rx_valid <= w_rx_valid;
      r_rx_data  <= w_rx_data;
      r_busy     <= w_busy;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (w_start) begin
      w_next_state = S_ADDR;
    end else if (w_stop) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_ADDR:  if (w_scl_rise && r_cnt == 4'd7) w_next_state = w_addr_hit ? S_ACK_A : S_IDLE;
        S_ACK_A: if (w_scl_fall && r_phase) w_next_state = r_shift[0] ? S_RD : S_WR;
        S_ACK_W: if (w_scl_fall && r_phase) w_next_state = S_WR;
        S_WR:    if (w_scl_rise && r_cnt == 4'd7) w_next_state = S_ACK_W;
        S_RD:    if (w_scl_fall && r_cnt == 4'd8) w_next_state = S_ACK_R;
        S_ACK_R: begin
          if (w_scl_rise && r_sda_s2) w_next_state = S_IDLE;
          else if (w_scl_fall && r_phase) w_next_state = S_RD;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_shift    = r_shift;
    w_cnt      = r_cnt;
    w_phase    = r_phase;
    w_sda_oe   = r_sda_oe;
    w_tx_req   = 1'b0;
    w_rx_valid = 1'b0;
    w_rx_data  = r_rx_data;
    w_busy     = r_busy;
    if (w_start) begin
      w_cnt    = '0;
      w_phase  = 1'b0;
      w_sda_oe = 1'b0;
    end else if (w_stop) begin
      w_cnt    = '0;
      w_phase  = 1'b0;
      w_sda_oe = 1'b0;
      w_busy   = 1'b0;
    end else begin
      case (r_state)
        S_ADDR: if (w_scl_rise) begin
          w_shift = {r_shift[6:0], r_sda_s2};
          w_cnt   = r_cnt + 4'd1;
          if (r_cnt == 4'd7) begin
            w_cnt   = '0;
            w_phase = 1'b0;
            w_busy  = w_addr_hit;
          end
        end
        S_ACK_A, S_ACK_W: if (w_scl_fall) begin
          if (!r_phase) begin
            w_sda_oe = 1'b1;
            w_phase  = 1'b1;
          end else begin
            w_sda_oe = 1'b0;
            w_phase  = 1'b0;
            w_cnt    = '0;
            if (r_state == S_ACK_A && r_shift[0]) begin
              w_shift  = tx_data;
              w_tx_req = 1'b1;
              w_sda_oe = ~tx_data[7];
            end
          end
        end
        S_WR: if (w_scl_rise) begin
          w_shift = {r_shift[6:0], r_sda_s2};
          w_cnt   = r_cnt + 4'd1;
          if (r_cnt == 4'd7) begin
            w_rx_data  = {r_shift[6:0], r_sda_s2};
            w_rx_valid = 1'b1;
            w_cnt      = '0;
            w_phase    = 1'b0;
          end
        end
        S_RD: begin
          if (w_scl_rise) begin
            w_cnt = r_cnt + 4'd1;
          end else if (w_scl_fall) begin
            if (r_cnt == 4'd8) begin
              w_sda_oe = 1'b0;
              w_phase  = 1'b0;
            end else begin
              w_shift  = {r_shift[6:0], 1'b0};
              w_sda_oe = ~r_shift[6];
            end
          end
        end
        S_ACK_R: begin
          if (w_scl_rise) begin
            w_phase  = ~r_sda_s2;
            w_sda_oe = 1'b0;
          end else if (w_scl_fall && r_phase) begin
            w_shift  = tx_data;
            w_tx_req = 1'b1;
            w_sda_oe = ~tx_data[7];
            w_cnt    = '0;
            w_phase  = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign sda_oe   = r_sda_oe;
  assign tx_req   = r_tx_req;
  assign rx_valid = r_rx_valid;
  assign rx_data  = r_rx_data;
  assign busy     = r_busy;
  assign state    = r_state;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: a bit-level bus master with an open-drain SDA model, checked
// against expectations derived from the transaction (address match, bytes sent/returned).
module tb_i2c_target;

  localparam logic [6:0] MY_ADDR = 7'h47;

  logic       clk = 1'b0;
  logic       reset;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       f_en  = 1'b0;
  logic       f_val = 1'b1;
  logic       bus_sda;
  logic       sda_oe, tx_req, rx_valid, busy;
  logic [7:0] tx_data, rx_data;
  logic [2:0] state;

  int unsigned checks = 0;
  int unsigned errors = 0;

  int unsigned mon_rxv = 0, mon_txr = 0, mon_both = 0, mon_oe_cyc = 0, mon_oe_bad = 0;
  logic [7:0]  mon_last_rx = 8'h00;

  logic [7:0] wdata[4];
  logic [7:0] rdata[4];

  assign bus_sda = f_en ? f_val : (m_sda & ~sda_oe);

  i2c_target #(.ADDR(7'b1000111)) dut (
    .clk      (clk),
    .reset    (reset),
    .scl      (m_scl),
    .sda_in   (bus_sda),
    .sda_oe   (sda_oe),
    .tx_data  (tx_data),
    .tx_req   (tx_req),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .busy     (busy),
    .state    (state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) begin
      mon_rxv     <= mon_rxv + 1;
      mon_last_rx <= rx_data;
    end
    if (tx_req) mon_txr <= mon_txr + 1;
    if (tx_req && rx_valid) mon_both <= mon_both + 1;
    if (sda_oe) mon_oe_cyc <= mon_oe_cyc + 1;
    if (sda_oe && !(state == 3'd2 || state == 3'd4 || state == 3'd5)) mon_oe_bad <= mon_oe_bad + 1;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors + 1);
    $fatal(1, "timeout");
  end

  function automatic logic model_hit(input logic [7:0] ab);
    return ab[7:1] == MY_ADDR;
  endfunction

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    clks(4); m_sda = b; clks(4); m_scl = 1'b1; clks(8); m_scl = 1'b0;
  endtask

  task automatic recv_bit(output logic b);
    clks(4); m_sda = 1'b1; clks(4); m_scl = 1'b1; clks(4); b = bus_sda; clks(4); m_scl = 1'b0;
  endtask

  task automatic do_start();
    if (m_scl == 1'b0) begin
      clks(4); m_sda = 1'b1; clks(4); m_scl = 1'b1; clks(8);
    end
    m_sda = 1'b0; clks(8); m_scl = 1'b0;
  endtask

  task automatic do_stop();
    clks(4); m_sda = 1'b0; clks(4); m_scl = 1'b1; clks(8); m_sda = 1'b1; clks(16);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ackn);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    recv_bit(ackn);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tx_data = 8'h00;
    clks(4);
    checks++; if (sda_oe !== 1'b0)     begin errors++; $display("FAIL reset_sda_oe: got %b expected 0", sda_oe); end
    checks++; if (tx_req !== 1'b0)     begin errors++; $display("FAIL reset_tx_req: got %b expected 0", tx_req); end
    checks++; if (rx_valid !== 1'b0)   begin errors++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
    checks++; if (rx_data !== 8'h00)   begin errors++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (state !== 3'd0)      begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
    reset = 1'b1;
    clks(10);
  endtask

  task automatic run_write(input logic [7:0] ab, input int n);
    logic ackn, hit;
    int unsigned rx0, oe0;
    hit = model_hit(ab);
    rx0 = mon_rxv;
    oe0 = mon_oe_cyc;
    do_start();
    write_byte(ab, ackn);
    checks++; if (ackn !== ~hit) begin errors++; $display("FAIL wr_addr_ack: got %b expected %b", ackn, ~hit); end
    checks++; if (busy !== hit)  begin errors++; $display("FAIL wr_busy_addr: got %b expected %b", busy, hit); end
    for (int i = 0; i < n; i++) begin
      write_byte(wdata[i], ackn);
      checks++; if (ackn !== ~hit) begin errors++; $display("FAIL wr_data_ack: byte %0d got %b expected %b", i, ackn, ~hit); end
    end
    clks(2);
    checks++;
    if (mon_rxv - rx0 !== (hit ? n : 0)) begin
      errors++; $display("FAIL wr_rx_count: got %0d expected %0d", mon_rxv - rx0, hit ? n : 0);
    end
    if (hit) begin
      checks++; if (mon_last_rx !== wdata[n-1]) begin errors++; $display("FAIL wr_rx_data: got %h expected %h", mon_last_rx, wdata[n-1]); end
    end else begin
      checks++; if (mon_oe_cyc != oe0) begin errors++; $display("FAIL wr_mismatch_oe: got %0d cycles expected 0", mon_oe_cyc - oe0); end
    end
    do_stop();
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL wr_busy_stop: got %b expected 0", busy); end
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL wr_state_end: got %0d expected 0", state); end
  endtask

  task automatic run_read(input int n);
    logic ackn, b;
    logic [7:0] d;
    int unsigned tr0;
    tr0 = mon_txr;
    d = 8'h00;
    tx_data = rdata[0];
    do_start();
    write_byte({MY_ADDR, 1'b1}, ackn);
    checks++; if (ackn !== 1'b0) begin errors++; $display("FAIL rd_addr_ack: got %b expected 0", ackn); end
    for (int i = 0; i < n; i++) begin
      for (int k = 7; k >= 0; k--) begin
        recv_bit(b);
        d[k] = b;
        if (k == 4 && i + 1 < n) tx_data = rdata[i+1];
      end
      checks++; if (d !== rdata[i]) begin errors++; $display("FAIL rd_byte: byte %0d got %h expected %h", i, d, rdata[i]); end
      send_bit(i == n - 1);
    end
    clks(4);
    checks++; if (mon_txr - tr0 !== n) begin errors++; $display("FAIL rd_tx_req_count: got %0d expected %0d", mon_txr - tr0, n); end
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL rd_state_nack: got %0d expected 0", state); end
    checks++; if (busy !== 1'b1)  begin errors++; $display("FAIL rd_busy_nack: got %b expected 1", busy); end
    do_stop();
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL rd_busy_stop: got %b expected 0", busy); end
  endtask

  task automatic test_write();
    wdata[0] = 8'hB4;
    run_write(8'h8E, 1);
  endtask

  task automatic test_mismatch();
    wdata[0] = 8'h55;
    run_write(8'hE6, 1);
  endtask

  task automatic test_read();
    rdata[0] = 8'hC9;
    run_read(1);
    rdata[0] = 8'hA5;
    rdata[1] = 8'h3C;
    run_read(2);
  endtask

  task automatic test_repeated_start();
    logic ackn, b;
    logic [7:0] d;
    int unsigned rx0, tr0;
    rx0 = mon_rxv;
    tr0 = mon_txr;
    d = 8'h00;
    tx_data = 8'h6B;
    do_start();
    write_byte(8'h8E, ackn);
    checks++; if (ackn !== 1'b0) begin errors++; $display("FAIL rs_addr_ack: got %b expected 0", ackn); end
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    do_start();
    write_byte(8'h8F, ackn);
    checks++; if (ackn !== 1'b0) begin errors++; $display("FAIL rs_addr2_ack: got %b expected 0", ackn); end
    for (int k = 7; k >= 0; k--) begin
      recv_bit(b);
      d[k] = b;
    end
    send_bit(1'b1);
    checks++; if (d !== 8'h6B) begin errors++; $display("FAIL rs_read_byte: got %h expected 6b", d); end
    do_stop();
    checks++; if (mon_rxv != rx0)     begin errors++; $display("FAIL rs_no_rx_valid: got %0d pulses expected 0", mon_rxv - rx0); end
    checks++; if (mon_txr - tr0 != 1) begin errors++; $display("FAIL rs_tx_req: got %0d pulses expected 1", mon_txr - tr0); end
  endtask

  task automatic test_abort_stop();
    logic ackn, b;
    tx_data = 8'hA5;
    do_start();
    write_byte(8'h8F, ackn);
    checks++; if (ackn !== 1'b0) begin errors++; $display("FAIL ab_addr_ack: got %b expected 0", ackn); end
    recv_bit(b); recv_bit(b); recv_bit(b);
    clks(4); m_sda = 1'b1; clks(4); m_scl = 1'b1; clks(4);
    checks++; if (sda_oe !== 1'b1) begin errors++; $display("FAIL ab_driving: got %b expected 1", sda_oe); end
    f_val = 1'b0; f_en = 1'b1;
    clks(4);
    f_val = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (state !== 3'd5) begin errors++; $display("FAIL ab_state_early: got %0d expected 5", state); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL ab_release: got %b expected 0", sda_oe); end
    checks++; if (state !== 3'd0)  begin errors++; $display("FAIL ab_state_idle: got %0d expected 0", state); end
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL ab_busy: got %b expected 0", busy); end
    clks(4);
    f_en = 1'b0;
    clks(8);
  endtask

  task automatic test_reset_mid_ack();
    logic ackn;
    do_start();
    write_byte(8'h8E, ackn);
    for (int i = 7; i >= 0; i--) send_bit(i[0]);
    clks(4); m_sda = 1'b1; clks(4); m_scl = 1'b1; clks(4);
    checks++; if (state !== 3'd4) begin errors++; $display("FAIL rm_state_ackw: got %0d expected 4", state); end
    #2 reset = 1'b0;
    #1;
    checks++; if (sda_oe !== 1'b0)   begin errors++; $display("FAIL rm_sda_oe: got %b expected 0", sda_oe); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rm_rx_data: got %h expected 00", rx_data); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL rm_busy: got %b expected 0", busy); end
    checks++; if (state !== 3'd0)    begin errors++; $display("FAIL rm_state: got %0d expected 0", state); end
    checks++; if ((tx_req | rx_valid) !== 1'b0) begin errors++; $display("FAIL rm_pulses: got %b%b expected 00", tx_req, rx_valid); end
    clks(3);
    reset = 1'b1;
    clks(10);
  endtask

  task automatic test_random();
    int kind, n;
    logic [6:0] a;
    for (int it = 0; it < 8; it++) begin
      kind = int'($urandom_range(0, 2));
      n = int'($urandom_range(1, 3));
      for (int j = 0; j < 4; j++) begin
        wdata[j] = 8'($urandom);
        rdata[j] = 8'($urandom);
      end
      if (kind == 0) begin
        run_write({MY_ADDR, 1'b0}, n);
      end else if (kind == 1) begin
        a = 7'($urandom_range(0, 127));
        if (a == MY_ADDR) a = a ^ 7'h10;
        run_write({a, 1'b0}, n);
      end else begin
        run_read(n);
      end
    end
  endtask

  task automatic test_invariants();
    checks++; if (mon_both != 0)   begin errors++; $display("FAIL inv_pulse_overlap: got %0d expected 0", mon_both); end
    checks++; if (mon_oe_bad != 0) begin errors++; $display("FAIL inv_oe_state: got %0d expected 0", mon_oe_bad); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_mismatch();
    test_read();
    test_repeated_start();
    test_abort_stop();
    test_reset_mid_ack();
    test_random();
    test_invariants();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
